bch_chieny_search_par: RTL
==========================

# bch_chieny_search_par

Parallel Chien search for the BCH decoder: it takes the error-locator polynomial from any Berlekamp variant (ibm, sribm2, ribm_2t_by_t, …) and tests P codeword positions per clock. It emits a per-position error mask in codeword order, plus a root count and a decoder-failure flag. It is the parametrised successor of `bch_chieny_search`, generalised in field size, code length, correction power and parallelism, and it sits between the Berlekamp stage and the error-correcting XOR stage.

## Interface
- M, 7, GF(2^M) symbol width
- N, 127, code length in bits, 2 ≤ N ≤ 2^M−1 (N < 2^M−1 is a shortened code)
- T, 10, correction power; locator has T+1 coefficients
- P, 4, positions tested per clock, 1 ≤ P ≤ 16
- PRIM_POLY, 'h89, field primitive polynomial (bit M set)
- iclk  in  1  clock
- ireset  in  1  synchronous reset, active high
- iclkena  in  1  clock enable; when low, all state and outputs hold
- iloc_poly_val  in  1  locator strobe, one cycle
- iloc_poly  in  (T+1)×M  λ0..λT, index 0 = constant term
- iloc_poly_deg  in  M  locator degree from Berlekamp
- iloc_decfail  in  1  upstream failure flag
- obusy  out  1  frame in progress; iloc_poly_val ignored while high
- osop  out  1  first error-mask beat
- oval  out  1  error-mask beat valid
- oeop  out  1  last error-mask beat
- oerr  out  P  bit p set = error at position k·P+p on beat k
- odone  out  1  frame summary valid, one cycle
- oerr_cnt  out  M  number of roots found
- odecfail  out  1  frame failure

## Operation
- K = ceil(N/P) beats per frame; S = 2^M−1−N.
- Position i (0 = first transmitted bit) is in error iff Λ(α^(i+1+S)) = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - iloc_poly_val with iclkena high latches λ, deg and decfail.
  - Register r_l is loaded with λ_l·α^(l·(1+S)), l = 0..T.
  - Go to RUN.
- RUN:
  - Lane p forms Σ_l r_l·α^(l·p) with constant multipliers; zero result → mask bit set.
  - Each beat, r_l ← r_l·α^(l·P).
  - Beat counter runs 0..K−1; on the last beat, lanes with k·P+p ≥ N are forced to 0.
  - After beat K−1, go to DONE.
- DONE:
  - odone is asserted for one cycle; return to IDLE.
- oerr_cnt accumulates popcount(oerr) over the frame, saturating at 2^M−1.
- All GF products are mod PRIM_POLY and computed combinationally; there are no general multipliers, only constant multipliers.
- iloc_poly_val while obusy is high is dropped and has no side effect.
- ireset mid-frame aborts to IDLE; no oeop or odone is issued for the aborted frame.

## Timing
- Reset values: obusy, osop, oval, oeop, oerr, odone, oerr_cnt, odecfail all 0; FSM IDLE.
- iloc_poly_val accepted at cycle 0.
- obusy is high from cycle 1 through the odone cycle inclusive.
- Mask beats are registered on cycles 2..K+1:
  - osop with beat 0.
  - oeop with beat K−1.
  - oval high for every beat.
  - If K=1, osop and oeop are asserted together.
- odone, oerr_cnt and odecfail are valid on cycle K+2.
- oerr_cnt and odecfail hold until the next accepted frame's osop.
- Earliest next accept is cycle K+3 (throughput: K+3 clocks per polynomial).
- iclkena low stretches every cycle count above 1:1; no beat is lost or repeated.

## Configuration
- BCH_CHIEN_DEG_CHECK_EN defined: odecfail = latched iloc_decfail OR (oerr_cnt ≠ iloc_poly_deg).
- BCH_CHIEN_DEG_CHECK_EN undefined: odecfail = latched iloc_decfail only, and the comparator is removed.
- oerr_cnt is produced in both builds.

## Test plan
All scenarios use M=4, N=15, T=3, P=4, PRIM_POLY='h13, so K=4, unless stated.
- Λ=1, deg 0: 4 beats, all oerr=0 → odone on cycle 6, oerr_cnt=0, odecfail=0.
- Single error at position 5: Λ=1+α^(-6)x, deg 1 → beat 1 oerr=4'b0010 only, oerr_cnt=1, odecfail=0.
- Degree mismatch: Λ=1+α^3x, deg=2:
  - oerr_cnt=1 in both builds.
  - odecfail=1 with BCH_CHIEN_DEG_CHECK_EN; odecfail=0 without it.
- Shortened code, N=13, Λ with a root at position 12:
  - Beat 3 has bit 0 set and bits 1..3 forced 0.
  - oerr_cnt=1.
- Handshake:
  - Second iloc_poly_val on cycle 3 is ignored, with exactly one frame output.
  - Val on cycle 7 is accepted, with osop on cycle 9.
- Reset and clock enable:
  - ireset on cycle 3 → no oeop/odone, and all outputs are 0 on cycle 4.
  - Toggling iclkena 1/0 doubles every latency, and the mask is identical to the ungated run.

Source files
------------

// File: rtl/bch_chieny_search_par.sv
// Parallel Chien search: evaluates the error locator at P codeword positions per clock.
// Define BCH_CHIEN_DEG_CHECK_EN to also flag frames whose root count differs from the locator degree.

module bch_chieny_lane #(
  parameter int         M         = 7,
  parameter int         T         = 10,
  parameter int         LANE      = 0,
  parameter logic [M:0] PRIM_POLY = 'h89
) (
  input  logic [T:0][M-1:0] r,
  output logic              zero
);
  localparam int Q = (1 << M) - 1;

  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  // Constant multiply by alpha^e: e is elaboration-constant at every call site.
  function automatic logic [M-1:0] cmul(input logic [M-1:0] a, input int e);
    logic [M-1:0] x;
    x = a;
    for (int i = 0; i < e % Q; i++) x = xtime(x);
    return x;
  endfunction

  logic [M-1:0] sum;

  always_comb begin
    sum = '0;
    for (int l = 0; l <= T; l++) sum ^= cmul(r[l], l * LANE);
  end

  assign zero = (sum == '0);
endmodule

module bch_chieny_search_par #(
  parameter int         M         = 7,
  parameter int         N         = 127,
  parameter int         T         = 10,
  parameter int         P         = 4,
  parameter logic [M:0] PRIM_POLY = 'h89
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                iloc_poly_val,
  input  logic [T:0][M-1:0]   iloc_poly,
  input  logic [M-1:0]        iloc_poly_deg,
  input  logic                iloc_decfail,
  output logic                obusy,
  output logic                osop,
  output logic                oval,
  output logic                oeop,
  output logic [P-1:0]        oerr,
  output logic                odone,
  output logic [M-1:0]        oerr_cnt,
  output logic                odecfail
);
  localparam int Q  = (1 << M) - 1;
  localparam int S  = Q - N;
  localparam int K  = (N + P - 1) / P;
  localparam int BW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  function automatic logic [M-1:0] cmul(input logic [M-1:0] a, input int e);
    logic [M-1:0] x;
    x = a;
    for (int i = 0; i < e % Q; i++) x = xtime(x);
    return x;
  endfunction

  logic [T:0][M-1:0] r, r_init, r_step;
  logic [BW-1:0]     beat;
  logic              last, accept, dec_r, fail_nxt;
  logic [P-1:0]      zero, hit;
  logic [M+4:0]      cnt_sum;

  assign last   = (beat == BW'(K - 1));
  // odone cycle still counts as busy so the next accept lands no earlier than K+3
  assign obusy  = (state != IDLE) || odone;
  assign accept = (state == IDLE) && iloc_poly_val && !odone;

  // r_l starts at lambda_l*alpha^(l(1+S)) so lane p of beat k tests alpha^(kP+p+1+S)
  for (genvar l = 0; l <= T; l++) begin : g_coef
    assign r_init[l] = cmul(iloc_poly[l], l * (1 + S));
    assign r_step[l] = cmul(r[l], l * P);
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    localparam bit PAD = ((K - 1) * P + p) >= N;
    bch_chieny_lane #(.M(M), .T(T), .LANE(p), .PRIM_POLY(PRIM_POLY)) u_lane (
      .r    (r),
      .zero (zero[p])
    );
    assign hit[p] = zero[p] && !(PAD && last);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_sum = ((beat == '0) ? '0 : (M+5)'(oerr_cnt)) + (M+5)'($countones(hit));

`ifdef BCH_CHIEN_DEG_CHECK_EN
  logic [M-1:0] deg_r;
  always_ff @(posedge iclk) begin
    if (ireset)                deg_r <= '0;
    else if (iclkena && accept) deg_r <= iloc_poly_deg;
  end
  assign fail_nxt = dec_r || (oerr_cnt != deg_r);
`else
  logic deg_unused;
  assign deg_unused = ^iloc_poly_deg;
  assign fail_nxt   = dec_r;
`endif

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state    <= IDLE;
      beat     <= '0;
      r        <= '0;
      dec_r    <= 1'b0;
      osop     <= 1'b0;
      oval     <= 1'b0;
      oeop     <= 1'b0;
      oerr     <= '0;
      odone    <= 1'b0;
      oerr_cnt <= '0;
      odecfail <= 1'b0;
    end else if (iclkena) begin
      state <= state_nxt;
      osop  <= (state == RUN) && (beat == '0);
      oval  <= (state == RUN);
      oeop  <= (state == RUN) && last;
      oerr  <= (state == RUN) ? hit : '0;
      odone <= (state == DONE);
      if (accept) begin
        r     <= r_init;
        beat  <= '0;
        dec_r <= iloc_decfail;
      end else if (state == RUN) begin
        r    <= r_step;
        beat <= beat + 1'b1;
      end
      // count restarts on beat 0, so the previous frame's total holds until osop
      if (state == RUN)
        oerr_cnt <= (cnt_sum > (M+5)'(Q)) ? M'(Q) : cnt_sum[M-1:0];
      if (state == DONE)
        odecfail <= fail_nxt;
    end
  end
endmodule
